pgm_arb: RTL and testbench
==========================

PGM_ARB -- requirements
Module: pgm_arb

Interface
REQ-001 Parameter TIMEOUT, default 16: number of cycles a granted source may take to deliver its head word.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s0_req / s1_req  input  1  source has a whole packet pending (s0 = bypass traffic, s1 = generated traffic).
REQ-005 s0_gnt / s1_gnt  output  1  registered grant; at most one high.
REQ-006 sN_data  input  134  packet word; [133:132] 01 = head, 11 = middle, 10 = tail.
REQ-007 sN_data_wr, sN_valid, sN_valid_wr, sN_phv_wr  input  1 each  word strobes/flags per source.
REQ-008 sN_phv  input  1024  per-word PHV per source.
REQ-009 out_data 134, out_data_wr 1, out_valid 1, out_valid_wr 1, out_phv 1024, out_phv_wr 1  output  merged registered stream.
REQ-010 in_alf  input  1  downstream almost-full.
REQ-011 s0_pkt_cnt / s1_pkt_cnt  output  32  tails forwarded per source.
REQ-012 tmo_cnt  output  32  grants revoked by timeout.

Function
REQ-013 States: IDLE_S, GNT_S (grant issued, awaiting head), XFER_S (streaming to tail).
REQ-014 IDLE_S: with in_alf=0 and any req, pick owner, assert its gnt next cycle, go GNT_S; with in_alf=1 no grant issued.
REQ-015 Arbitration: round-robin on a last-owner pointer; if both req, grant the source not served last; single req granted regardless of pointer.
REQ-016 Pointer updates to owner on completed tail or on timeout.
REQ-017 GNT_S: owner data_wr=1 with [133:132]=01 -> forward word, go XFER_S.
REQ-018 GNT_S: owner data_wr=1 with non-head tag -> word discarded, stay GNT_S.
REQ-019 GNT_S timeout: wait counter clears on entry, increments per cycle without head; at TIMEOUT-1 -> IDLE_S, gnt low next cycle, tmo_cnt+1, pointer = owner.
REQ-020 XFER_S: every owner word with data_wr=1 forwarded; in_alf ignored mid-packet (alf slack covers packet).
REQ-021 XFER_S: owner tail (10) with data_wr=1 -> forward, sN_pkt_cnt+1, go IDLE_S; gnt low the following cycle.
REQ-022 Head tag in XFER_S forwarded as ordinary word, no state change.
REQ-023 Forwarding latency exactly 1 cycle: out_* = owner's inputs registered; out_data_wr=1 only for forwarded words.
REQ-024 When no word forwarded: out_data_wr, out_valid, out_valid_wr, out_phv_wr = 0; out_data, out_phv hold zero.
REQ-025 Non-owner writes always ignored; no buffering inside block.
REQ-026 Earliest re-grant: the cycle after returning to IDLE_S (one idle cycle between packets).
REQ-027 All 32-bit counters wrap modulo 2^32, no saturation.
REQ-028 Owner deasserting req after grant has no effect; grant ends only by tail or timeout.

Reset
REQ-029 rst_n low: state IDLE_S, both gnt 0, all out_* 0, all counters 0, wait counter 0, pointer = s1 (so s0 wins first tie).
REQ-030 Reset mid-packet: partial packet abandoned, no tail emitted; after release arbitration restarts from IDLE_S.

Verification
REQ-031 Both req from reset, s0 4-word pkt then s1 3-word pkt -> s0_gnt first, out stream 01,11,11,10 then 01,11,10 each 1 cycle late; s0_pkt_cnt=1, s1_pkt_cnt=1.
REQ-032 s1 req held, s1 never sends head, TIMEOUT=16 -> s1_gnt low 16 cycles after assert edge +1; tmo_cnt=1; no out_data_wr.
REQ-033 in_alf=1 with s0_req=1 for 20 cycles -> no gnt; in_alf drops -> s0_gnt high 1 cycle later.
REQ-034 s0 granted, s1 drives words concurrently -> only s0 words appear on out; s1_pkt_cnt unchanged.
REQ-035 rst_n pulsed low during s0 middle words -> outputs zero immediately, s0_gnt 0; after release both req -> s0 granted first.
REQ-036 Continuous req both sources, 6 packets -> grants alternate s0,s1,s0,s1,s0,s1; counters 3 and 3.

Source files
------------

// File: rtl/pgm_arb.sv
// pgm_arb -- two-source whole-packet arbiter with a merged, registered output.
//
// Source 0 carries bypass traffic and source 1 carries generated traffic. A
// source holds its req high while a complete packet is pending. The arbiter
// grants one source at a time and forwards that owner's words, one cycle
// late, until the tail word. If the owner does not deliver a head word within
// TIMEOUT cycles of the grant, the grant is withdrawn.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   sN_req / sN_gnt        packet pending / registered grant (at most one high)
//   sN_data[133:0]         word; [133:132] 01 head, 11 middle, 10 tail
//   sN_data_wr             word strobe
//   sN_valid, sN_valid_wr  valid flag and its strobe
//   sN_phv[1023:0]         per-word PHV
//   sN_phv_wr              PHV strobe
//   in_alf                 downstream almost-full; blocks only new grants
//   out_*                  merged registered stream (all zero when idle)
//   s0_pkt_cnt, s1_pkt_cnt tails forwarded per source (wrap at 2^32)
//   tmo_cnt                grants withdrawn by timeout (wraps at 2^32)
module pgm_arb #(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s0_req,
   output logic          s0_gnt,
   input  logic [133:0]  s0_data,
   input  logic          s0_data_wr,
   input  logic          s0_valid,
   input  logic          s0_valid_wr,
   input  logic [1023:0] s0_phv,
   input  logic          s0_phv_wr,
   input  logic          s1_req,
   output logic          s1_gnt,
   input  logic [133:0]  s1_data,
   input  logic          s1_data_wr,
   input  logic          s1_valid,
   input  logic          s1_valid_wr,
   input  logic [1023:0] s1_phv,
   input  logic          s1_phv_wr,
   input  logic          in_alf,
   output logic [133:0]  out_data,
   output logic          out_data_wr,
   output logic          out_valid,
   output logic          out_valid_wr,
   output logic [1023:0] out_phv,
   output logic          out_phv_wr,
   output logic [31:0]   s0_pkt_cnt,
   output logic [31:0]   s1_pkt_cnt,
   output logic [31:0]   tmo_cnt
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_TAIL = 2'b10;

   typedef enum logic [1:0] {IDLE_S, GNT_S, XFER_S} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;   // 0 = s0, 1 = s1
   logic                last_q, last_d;     // source served last
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                s0_gnt_q, s0_gnt_d, s1_gnt_q, s1_gnt_d;
   logic [133:0]        out_data_q, out_data_d;
   logic                out_data_wr_q, out_data_wr_d;
   logic                out_valid_q, out_valid_d;
   logic                out_valid_wr_q, out_valid_wr_d;
   logic [1023:0]       out_phv_q, out_phv_d;
   logic                out_phv_wr_q, out_phv_wr_d;
   logic [31:0]         s0_pkt_cnt_q, s0_pkt_cnt_d;
   logic [31:0]         s1_pkt_cnt_q, s1_pkt_cnt_d;
   logic [31:0]         tmo_cnt_q, tmo_cnt_d;
   logic                pick;
   logic                fwd;

   // Current owner's word; the other source is never looked at.
   logic [133:0]  own_data;
   logic          own_data_wr, own_valid, own_valid_wr, own_phv_wr;
   logic [1023:0] own_phv;
   logic [1:0]    own_tag;

   assign own_data     = owner_q ? s1_data     : s0_data;
   assign own_data_wr  = owner_q ? s1_data_wr  : s0_data_wr;
   assign own_valid    = owner_q ? s1_valid    : s0_valid;
   assign own_valid_wr = owner_q ? s1_valid_wr : s0_valid_wr;
   assign own_phv      = owner_q ? s1_phv      : s0_phv;
   assign own_phv_wr   = owner_q ? s1_phv_wr   : s0_phv_wr;
   assign own_tag      = own_data[133:132];

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      wait_d       = wait_q;
      s0_gnt_d     = s0_gnt_q;
      s1_gnt_d     = s1_gnt_q;
      s0_pkt_cnt_d = s0_pkt_cnt_q;
      s1_pkt_cnt_d = s1_pkt_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      pick         = 1'b0;
      fwd          = 1'b0;

      case (state_q)
         IDLE_S: begin
            wait_d = '0;
            if (!in_alf && (s0_req || s1_req)) begin
               // Tie goes to the source not served last; a lone req wins outright.
               pick     = (s0_req && s1_req) ? ~last_q : s1_req;
               owner_d  = pick;
               s0_gnt_d = ~pick;
               s1_gnt_d = pick;
               state_d  = GNT_S;
            end
         end
         GNT_S: begin
            if (own_data_wr && own_tag == TAG_HEAD) begin
               fwd     = 1'b1;
               state_d = XFER_S;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = IDLE_S;
               s0_gnt_d  = 1'b0;
               s1_gnt_d  = 1'b0;
               tmo_cnt_d = tmo_cnt_q + 32'd1;
               last_d    = owner_q;
            end else begin
               // Non-head words from the owner are dropped and count as waiting.
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         XFER_S: begin
            if (own_data_wr) begin
               fwd = 1'b1;
               if (own_tag == TAG_TAIL) begin
                  state_d  = IDLE_S;
                  s0_gnt_d = 1'b0;
                  s1_gnt_d = 1'b0;
                  last_d   = owner_q;
                  if (owner_q) s1_pkt_cnt_d = s1_pkt_cnt_q + 32'd1;
                  else         s0_pkt_cnt_d = s0_pkt_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE_S;
      endcase

      // Output stream is zero on any cycle that forwards nothing.
      out_data_d     = fwd ? own_data     : '0;
      out_data_wr_d  = fwd;
      out_valid_d    = fwd ? own_valid    : 1'b0;
      out_valid_wr_d = fwd ? own_valid_wr : 1'b0;
      out_phv_d      = fwd ? own_phv      : '0;
      out_phv_wr_d   = fwd ? own_phv_wr   : 1'b0;
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE_S;
         owner_q        <= 1'b0;
         last_q         <= 1'b1;   // s1 counts as served last, so s0 wins the first tie
         wait_q         <= '0;
         s0_gnt_q       <= 1'b0;
         s1_gnt_q       <= 1'b0;
         out_data_q     <= '0;
         out_data_wr_q  <= 1'b0;
         out_valid_q    <= 1'b0;
         out_valid_wr_q <= 1'b0;
         out_phv_q      <= '0;
         out_phv_wr_q   <= 1'b0;
         s0_pkt_cnt_q   <= '0;
         s1_pkt_cnt_q   <= '0;
         tmo_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_q         <= last_d;
         wait_q         <= wait_d;
         s0_gnt_q       <= s0_gnt_d;
         s1_gnt_q       <= s1_gnt_d;
         out_data_q     <= out_data_d;
         out_data_wr_q  <= out_data_wr_d;
         out_valid_q    <= out_valid_d;
         out_valid_wr_q <= out_valid_wr_d;
         out_phv_q      <= out_phv_d;
         out_phv_wr_q   <= out_phv_wr_d;
         s0_pkt_cnt_q   <= s0_pkt_cnt_d;
         s1_pkt_cnt_q   <= s1_pkt_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
      end
   end

   assign s0_gnt       = s0_gnt_q;
   assign s1_gnt       = s1_gnt_q;
   assign out_data     = out_data_q;
   assign out_data_wr  = out_data_wr_q;
   assign out_valid    = out_valid_q;
   assign out_valid_wr = out_valid_wr_q;
   assign out_phv      = out_phv_q;
   assign out_phv_wr   = out_phv_wr_q;
   assign s0_pkt_cnt   = s0_pkt_cnt_q;
   assign s1_pkt_cnt   = s1_pkt_cnt_q;
   assign tmo_cnt      = tmo_cnt_q;

endmodule

// File: tb/tb_pgm_arb.sv
// tb_pgm_arb -- self-checking bench for pgm_arb. Words expected on the merged
// stream are queued with the cycle they must appear in; a negedge monitor
// pops and compares them, and checks the stream is all-zero otherwise.
module tb_pgm_arb;

   localparam int TIMEOUT = 16;
   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_MID  = 2'b11;
   localparam logic [1:0] TAG_TAIL = 2'b10;

   typedef struct {
      logic [133:0]  data;
      logic          valid;
      logic          valid_wr;
      logic [1023:0] phv;
      logic          phv_wr;
   } word_t;

   typedef struct {
      word_t w;
      int    cyc;
   } exp_t;

   logic          clk, rst_n;
   logic          s0_req, s0_gnt, s0_data_wr, s0_valid, s0_valid_wr, s0_phv_wr;
   logic [133:0]  s0_data;
   logic [1023:0] s0_phv;
   logic          s1_req, s1_gnt, s1_data_wr, s1_valid, s1_valid_wr, s1_phv_wr;
   logic [133:0]  s1_data;
   logic [1023:0] s1_phv;
   logic          in_alf;
   logic [133:0]  out_data;
   logic          out_data_wr, out_valid, out_valid_wr, out_phv_wr;
   logic [1023:0] out_phv;
   logic [31:0]   s0_pkt_cnt, s1_pkt_cnt, tmo_cnt;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   exp_s0 = 0;
   int   exp_s1 = 0;
   int   exp_tmo = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   pgm_arb #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_req(s0_req), .s0_gnt(s0_gnt), .s0_data(s0_data), .s0_data_wr(s0_data_wr),
      .s0_valid(s0_valid), .s0_valid_wr(s0_valid_wr), .s0_phv(s0_phv), .s0_phv_wr(s0_phv_wr),
      .s1_req(s1_req), .s1_gnt(s1_gnt), .s1_data(s1_data), .s1_data_wr(s1_data_wr),
      .s1_valid(s1_valid), .s1_valid_wr(s1_valid_wr), .s1_phv(s1_phv), .s1_phv_wr(s1_phv_wr),
      .in_alf(in_alf),
      .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
      .out_valid_wr(out_valid_wr), .out_phv(out_phv), .out_phv_wr(out_phv_wr),
      .s0_pkt_cnt(s0_pkt_cnt), .s1_pkt_cnt(s1_pkt_cnt), .tmo_cnt(tmo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: compares away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL sb_missing: word due at cycle %0d never seen (now %0d)", mon_e.cyc, cyc);
         end
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            mon_e = sb_q.pop_front();
            total++;
            if (out_data_wr !== 1'b1 || out_data !== mon_e.w.data || out_valid !== mon_e.w.valid ||
                out_valid_wr !== mon_e.w.valid_wr || out_phv !== mon_e.w.phv ||
                out_phv_wr !== mon_e.w.phv_wr) begin
               bad++;
               $display("FAIL sb_word: cyc=%0d got wr=%b data=%h expected wr=1 data=%h",
                        cyc, out_data_wr, out_data, mon_e.w.data);
            end
         end else begin
            total++;
            if (out_data_wr !== 1'b0 || out_data !== '0 || out_valid !== 1'b0 ||
                out_valid_wr !== 1'b0 || out_phv !== '0 || out_phv_wr !== 1'b0) begin
               bad++;
               $display("FAIL sb_idle: cyc=%0d got wr=%b data=%h expected all-zero stream",
                        cyc, out_data_wr, out_data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic make_word(input logic [1:0] tag, output word_t w);
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      w.data = {tag, r[131:0]};
      for (int i = 0; i < 32; i++) w.phv[i*32 +: 32] = $urandom();
      w.valid    = 1'($urandom_range(0, 1));
      w.valid_wr = 1'($urandom_range(0, 1));
      w.phv_wr   = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_word(input int src, input word_t w);
      if (src == 0) begin
         s0_data = w.data; s0_data_wr = 1'b1; s0_valid = w.valid;
         s0_valid_wr = w.valid_wr; s0_phv = w.phv; s0_phv_wr = w.phv_wr;
      end else begin
         s1_data = w.data; s1_data_wr = 1'b1; s1_valid = w.valid;
         s1_valid_wr = w.valid_wr; s1_phv = w.phv; s1_phv_wr = w.phv_wr;
      end
   endtask

   task automatic idle_src(input int src);
      if (src == 0) begin
         s0_data = '0; s0_data_wr = 1'b0; s0_valid = 1'b0;
         s0_valid_wr = 1'b0; s0_phv = '0; s0_phv_wr = 1'b0;
      end else begin
         s1_data = '0; s1_data_wr = 1'b0; s1_valid = 1'b0;
         s1_valid_wr = 1'b0; s1_phv = '0; s1_phv_wr = 1'b0;
      end
   endtask

   // Waits (bounded) for any grant; reports who and how many edges it took.
   task automatic wait_gnt(output int who, output int waited);
      waited = 0;
      while (waited < 100 && s0_gnt !== 1'b1 && s1_gnt !== 1'b1) begin
         step();
         waited++;
      end
      total++;
      if ((s0_gnt === 1'b1) == (s1_gnt === 1'b1)) begin
         bad++;
         $display("FAIL wait_gnt: s0_gnt=%b s1_gnt=%b after %0d cycles, expected exactly one",
                  s0_gnt, s1_gnt, waited);
      end
      who = (s1_gnt === 1'b1) ? 1 : 0;
   endtask

   // Sends an n-word packet from a source that already holds the grant.
   task automatic send_pkt(input int src, input int n, input bit noise, input bit alf_mid);
      word_t w, nw;
      exp_t  e;
      for (int i = 0; i < n; i++) begin
         make_word((i == 0) ? TAG_HEAD : (i == n - 1) ? TAG_TAIL : TAG_MID, w);
         drive_word(src, w);
         e.w = w;
         e.cyc = cyc + 1;
         sb_q.push_back(e);
         if (noise) begin
            make_word(2'($urandom_range(0, 3)), nw);
            drive_word(1 - src, nw);
         end
         if (alf_mid && i == 1) in_alf = 1'b1;
         step();
      end
      idle_src(0);
      idle_src(1);
      if (src == 0) exp_s0++;
      else          exp_s1++;
      total++;
      if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL gnt_after_tail: s0_gnt=%b s1_gnt=%b expected 0 0", s0_gnt, s1_gnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_alf = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
      idle_src(0);
      idle_src(1);
      #1;
      total++;
      if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0 || out_data_wr !== 1'b0 || out_data !== '0 ||
          out_valid !== 1'b0 || out_valid_wr !== 1'b0 || out_phv !== '0 || out_phv_wr !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: gnt=%b%b wr=%b data=%h expected all zero",
                  s0_gnt, s1_gnt, out_data_wr, out_data);
      end
      total++;
      if (s0_pkt_cnt !== 32'd0 || s1_pkt_cnt !== 32'd0 || tmo_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0", s0_pkt_cnt, s1_pkt_cnt, tmo_cnt);
      end
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      total++;
      if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_req: gnt=%b%b expected 00", s0_gnt, s1_gnt);
      end
   endtask

   task automatic test_basic();
      int who, waited;
      s0_req = 1'b1; s1_req = 1'b1;
      wait_gnt(who, waited);
      total++;
      if (who != 0 || waited != 1) begin
         bad++;
         $display("FAIL first_tie: who=%0d waited=%0d expected who=0 waited=1", who, waited);
      end
      send_pkt(0, 4, 1'b0, 1'b0);
      s0_req = 1'b0;
      wait_gnt(who, waited);
      total++;
      if (who != 1 || waited != 1) begin
         bad++;
         $display("FAIL second_grant: who=%0d waited=%0d expected who=1 waited=1", who, waited);
      end
      send_pkt(1, 3, 1'b0, 1'b0);
      s1_req = 1'b0;
      step();
      total++;
      if (s0_pkt_cnt !== 32'(exp_s0) || s1_pkt_cnt !== 32'(exp_s1) || tmo_cnt !== 32'(exp_tmo)) begin
         bad++;
         $display("FAIL basic_counts: got %0d %0d %0d expected %0d %0d %0d",
                  s0_pkt_cnt, s1_pkt_cnt, tmo_cnt, exp_s0, exp_s1, exp_tmo);
      end
   endtask

   task automatic timeout_one(input int src);
      int who, waited, held;
      if (src == 0) s0_req = 1'b1;
      else          s1_req = 1'b1;
      wait_gnt(who, waited);
      total++;
      if (who != src) begin
         bad++;
         $display("FAIL tmo_owner: who=%0d expected %0d", who, src);
      end
      held = 0;
      while ((s0_gnt === 1'b1 || s1_gnt === 1'b1) && held < 100) begin
         held++;
         step();
      end
      s0_req = 1'b0; s1_req = 1'b0;
      exp_tmo++;
      total++;
      if (held != TIMEOUT) begin
         bad++;
         $display("FAIL tmo_gnt_len: grant held %0d cycles expected %0d", held, TIMEOUT);
      end
      total++;
      if (tmo_cnt !== 32'(exp_tmo)) begin
         bad++;
         $display("FAIL tmo_cnt: got %0d expected %0d", tmo_cnt, exp_tmo);
      end
      step();
      step();
      total++;
      if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL tmo_regrant: gnt=%b%b expected 00 with req low", s0_gnt, s1_gnt);
      end
   endtask

   task automatic test_timeout();
      int who, waited;
      timeout_one(1);
      timeout_one(0);
      // The timed-out owner (s0) now counts as served last, so s1 wins the tie.
      s0_req = 1'b1; s1_req = 1'b1;
      wait_gnt(who, waited);
      s0_req = 1'b0;
      total++;
      if (who != 1) begin
         bad++;
         $display("FAIL tmo_pointer: who=%0d expected 1", who);
      end
      send_pkt(1, 2, 1'b0, 1'b0);
      s1_req = 1'b0;
      step();
   endtask

   task automatic test_discard();
      int who, waited;
      word_t w;
      s0_req = 1'b1;
      wait_gnt(who, waited);
      total++;
      if (who != 0) begin
         bad++;
         $display("FAIL discard_owner: who=%0d expected 0", who);
      end
      make_word(TAG_MID, w);
      drive_word(0, w);
      step();
      make_word(TAG_TAIL, w);
      drive_word(0, w);
      step();
      idle_src(0);
      step();
      send_pkt(0, 3, 1'b0, 1'b0);
      s0_req = 1'b0;
      step();
      total++;
      if (s0_pkt_cnt !== 32'(exp_s0)) begin
         bad++;
         $display("FAIL discard_count: s0_pkt_cnt=%0d expected %0d", s0_pkt_cnt, exp_s0);
      end
   endtask

   task automatic test_alf();
      int viol;
      in_alf = 1'b1;
      s0_req = 1'b1;
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL alf_block: %0d cycles granted while almost-full, expected 0", viol);
      end
      in_alf = 1'b0;
      step();
      total++;
      if (s0_gnt !== 1'b1 || s1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL alf_release: gnt=%b%b expected s0 granted (10)", s0_gnt, s1_gnt);
      end
      send_pkt(0, 5, 1'b0, 1'b1);
      s0_req = 1'b0;
      s1_req = 1'b1;
      viol = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL alf_after_pkt: %0d cycles granted while almost-full, expected 0", viol);
      end
      s1_req = 1'b0;
      in_alf = 1'b0;
      step();
   endtask

   task automatic test_non_owner();
      int who, waited;
      s0_req = 1'b1;
      wait_gnt(who, waited);
      total++;
      if (who != 0) begin
         bad++;
         $display("FAIL nonowner_owner: who=%0d expected 0", who);
      end
      send_pkt(0, 4, 1'b1, 1'b0);
      s0_req = 1'b0;
      step();
      total++;
      if (s1_pkt_cnt !== 32'(exp_s1) || s0_pkt_cnt !== 32'(exp_s0)) begin
         bad++;
         $display("FAIL nonowner_counts: got %0d %0d expected %0d %0d",
                  s0_pkt_cnt, s1_pkt_cnt, exp_s0, exp_s1);
      end
   endtask

   task automatic test_reset_mid();
      int who, waited;
      word_t w;
      exp_t  e;
      s0_req = 1'b1;
      wait_gnt(who, waited);
      make_word(TAG_HEAD, w);
      drive_word(0, w);
      e.w = w; e.cyc = cyc + 1; sb_q.push_back(e);
      step();
      make_word(TAG_MID, w);
      drive_word(0, w);
      e.w = w; e.cyc = cyc + 1; sb_q.push_back(e);
      step();
      make_word(TAG_MID, w);
      drive_word(0, w);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      exp_s0 = 0; exp_s1 = 0; exp_tmo = 0;
      total++;
      if (s0_gnt !== 1'b0 || out_data_wr !== 1'b0 || out_data !== '0 || out_phv !== '0 ||
          out_valid !== 1'b0 || out_valid_wr !== 1'b0 || out_phv_wr !== 1'b0) begin
         bad++;
         $display("FAIL midreset_outputs: gnt=%b wr=%b data=%h expected all zero",
                  s0_gnt, out_data_wr, out_data);
      end
      total++;
      if (s0_pkt_cnt !== 32'd0 || s1_pkt_cnt !== 32'd0 || tmo_cnt !== 32'd0) begin
         bad++;
         $display("FAIL midreset_counters: got %0d %0d %0d expected 0 0 0", s0_pkt_cnt, s1_pkt_cnt, tmo_cnt);
      end
      idle_src(0);
      s0_req = 1'b0;
      step();
      step();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      s0_req = 1'b1; s1_req = 1'b1;
      wait_gnt(who, waited);
      s1_req = 1'b0;
      total++;
      if (who != 0) begin
         bad++;
         $display("FAIL midreset_regrant: who=%0d expected 0", who);
      end
      send_pkt(0, 3, 1'b0, 1'b0);
      s0_req = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      int who, waited;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_s0 = 0; exp_s1 = 0; exp_tmo = 0;
      step();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      s0_req = 1'b1; s1_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_gnt(who, waited);
         total++;
         if (who != (k % 2) || waited != 1) begin
            bad++;
            $display("FAIL rr_grant%0d: who=%0d waited=%0d expected who=%0d waited=1",
                     k, who, waited, k % 2);
         end
         send_pkt(who, 2 + (k % 3), 1'b0, 1'b0);
      end
      s0_req = 1'b0; s1_req = 1'b0;
      step();
      total++;
      if (s0_pkt_cnt !== 32'd3 || s1_pkt_cnt !== 32'd3 || tmo_cnt !== 32'd0) begin
         bad++;
         $display("FAIL rr_counts: got %0d %0d %0d expected 3 3 0", s0_pkt_cnt, s1_pkt_cnt, tmo_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_discard();
      test_alf();
      test_non_owner();
      test_reset_mid();
      test_round_robin();
      step();
      step();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d expected words left, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
